// File: rtl/fma_operand_sequencer_if.sv
// Bundle of every handshake and data signal between the operand sequencer,
// its producer, the serial FMA unit and the result consumer.
//
// Handshake rules (both in_* and out_*): the source raises valid and holds
// valid plus its data stable until the cycle in which ready is also high;
// the transfer happens on the rising clock edge that closes that cycle.
// ready may depend on state only, never on valid.
interface fma_operand_sequencer_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic [31:0] in_c;
    logic        fma_start;
    logic [31:0] fma_float_in;
    logic [31:0] fma_float_out;
    logic        fma_ready;
    logic        fma_error;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic        out_error;

    // Sequencer side
    modport slave (
        input  in_valid, in_a, in_b, in_c,
        input  fma_float_out, fma_ready, fma_error,
        input  out_ready,
        output in_ready, fma_start, fma_float_in,
        output out_valid, out_result, out_error
    );

    // Environment side: producer, FMA unit and consumer
    modport master (
        output in_valid, in_a, in_b, in_c,
        output fma_float_out, fma_ready, fma_error,
        output out_ready,
        input  in_ready, fma_start, fma_float_in,
        input  out_valid, out_result, out_error
    );
endinterface

// File: rtl/fma_operand_sequencer.sv
// Operand sequencer for a serial single-precision FMA unit (y = a*b + c).
// Triples are queued in a small FIFO, then streamed one word per cycle
// (a with a start pulse, then b, then c) onto the FMA operand bus. The
// sequencer waits a bounded number of cycles for the FMA result, converts
// FMA errors and timeouts into an all-ones result with the error flag set,
// and holds the result until the consumer takes it. Only one triple is in
// flight at a time, so results leave in the order triples arrived.
module fma_operand_sequencer #(
    parameter int FIFO_DEPTH = 4,   // power of two, at least 2
    parameter int TIMEOUT    = 16   // WAIT cycles before a missing result is an error
) (
    input  logic                    clk,
    input  logic                    rst,
    fma_operand_sequencer_if.slave  bus,
    output logic [2:0]              dbg_state_o
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(TIMEOUT) + 1;

    localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);
    localparam logic [TW-1:0] LAST_WAIT = TW'(TIMEOUT - 1);
    localparam logic [31:0]   ERR_WORD  = 32'hFFFF_FFFF;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SEND_A = 3'd1,
        S_SEND_B = 3'd2,
        S_SEND_C = 3'd3,
        S_WAIT   = 3'd4,
        S_RESULT = 3'd5
    } state_e;

    state_e        state_q, state_d;

    logic [95:0]   mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    logic [95:0]   op_q, op_d;          // {a, b, c} of the triple in flight
    logic [TW-1:0] wait_cnt_q, wait_cnt_d;
    logic [31:0]   result_q, result_d;
    logic          error_q, error_d;

    logic          fifo_full;
    logic          fifo_empty;
    logic          push;
    logic          pop;

    // FIFO status. in_ready is forced low during reset so no triple can be
    // offered as accepted while the queue is being cleared.
    assign fifo_full    = (count_q == DEPTH_C);
    assign fifo_empty   = (count_q == '0);
    assign bus.in_ready = !fifo_full && !rst;
    assign push         = bus.in_valid && bus.in_ready;
    assign pop          = (state_q == S_IDLE) && !fifo_empty && !bus.out_valid;

    // Triple storage; contents are meaningless outside the count, so no reset
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {bus.in_a, bus.in_b, bus.in_c};
        end
    end

    // FIFO pointer and occupancy next-state; pointers wrap naturally
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state: FMA responses are only looked at while they can matter
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (!fifo_empty && !bus.out_valid) begin
                    state_d = S_SEND_A;
                end
            end
            S_SEND_A: state_d = S_SEND_B;
            S_SEND_B: state_d = bus.fma_error ? S_RESULT : S_SEND_C;
            S_SEND_C: state_d = bus.fma_error ? S_RESULT : S_WAIT;
            S_WAIT: begin
                if (bus.fma_ready || bus.fma_error || (wait_cnt_q == LAST_WAIT)) begin
                    state_d = S_RESULT;
                end
            end
            S_RESULT: begin
                if (bus.out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // FSM outputs: operand bus is driven only in the three send states
    always_comb begin
        bus.fma_start    = 1'b0;
        bus.fma_float_in = 32'h0;
        bus.out_valid    = 1'b0;
        case (state_q)
            S_SEND_A: begin
                bus.fma_start    = 1'b1;
                bus.fma_float_in = op_q[95:64];
            end
            S_SEND_B: bus.fma_float_in = op_q[63:32];
            S_SEND_C: bus.fma_float_in = op_q[31:0];
            S_RESULT: bus.out_valid    = 1'b1;
            default: ;
        endcase
    end

    assign bus.out_result = result_q;
    assign bus.out_error  = error_q;
    assign dbg_state_o    = state_q;

    // Datapath next-state: operand capture, WAIT counter, result capture.
    // A valid FMA result wins over a simultaneous error or timeout.
    always_comb begin
        op_d       = op_q;
        wait_cnt_d = '0;
        result_d   = result_q;
        error_d    = error_q;
        if (pop) begin
            op_d = mem_q[rd_ptr_q];
        end
        case (state_q)
            S_SEND_B, S_SEND_C: begin
                if (bus.fma_error) begin
                    result_d = ERR_WORD;
                    error_d  = 1'b1;
                end
            end
            S_WAIT: begin
                wait_cnt_d = wait_cnt_q + TW'(1);
                if (bus.fma_ready) begin
                    result_d = bus.fma_float_out;
                    error_d  = 1'b0;
                end else if (bus.fma_error || (wait_cnt_q == LAST_WAIT)) begin
                    result_d = ERR_WORD;
                    error_d  = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Datapath registers; reset discards queued and in-flight work
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            op_q       <= '0;
            wait_cnt_q <= '0;
            result_q   <= '0;
            error_q    <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            op_q       <= op_d;
            wait_cnt_q <= wait_cnt_d;
            result_q   <= result_d;
            error_q    <= error_d;
        end
    end

endmodule

// File: tb/tb_fma_operand_sequencer.sv
// Bench for fma_operand_sequencer: table vectors, corner-case sequences and
// random traffic against a transaction-level model and a behavioural FMA stub.
module tb_fma_operand_sequencer;

    localparam int FIFO_DEPTH = 4;
    localparam int TIMEOUT    = 16;

    // Stub behaviour codes per triple
    //   0 ready at WAIT cycle lat, 1 error in SEND_B, 2 error in SEND_C,
    //   3 error at WAIT cycle lat, 4 ready and error together at WAIT cycle lat
    //   lat outside 1..TIMEOUT means the stub never answers in WAIT.
    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] c;
        int          lat;
        int          err;
    } plan_t;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] c;
        int          lat;
        int          err;
        logic [31:0] exp_res;
        logic        exp_err;
    } vec_t;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [2:0] dbg_state;

    always #5 clk = ~clk;

    fma_operand_sequencer_if bus ();

    fma_operand_sequencer #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .TIMEOUT    (TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .dbg_state_o (dbg_state)
    );

    // ---------------- bookkeeping ----------------
    int          checks = 0;
    int          errors = 0;
    plan_t       plan_q[$];
    logic [32:0] exp_q[$];
    plan_t       cur;
    int          drv_lat = 0;
    int          drv_err = 0;
    logic [32:0] drv_exp = '0;
    int          cyc = 0;
    int          ph = 0;
    int          wcnt = 0;
    int          exp_ov_cyc = 0;
    bit          ov_pend = 0;
    bit          ov_prev = 0;
    int          push_cyc = 0;
    int          start_cyc = 0;
    logic [32:0] last_hs = '0;
    bit          spur_req = 0;
    bit          rnd_done = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t state=%0d)", name, act, exp, $time, dbg_state);
        end
    endtask

    // What the stub answers with when it reports a result
    function automatic logic [31:0] stub_fn(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
        if (a == 32'h3FE0_0000 && b == 32'h3FC0_0000 && c == 32'h3F80_0000) begin
            return 32'h4068_0000;   // 1.75 * 1.5 + 1.0 = 3.625
        end
        return a + b + c;
    endfunction

    function automatic bit lat_ok(input int lat);
        return (lat >= 1) && (lat <= TIMEOUT);
    endfunction

    // Transaction-level expectation {error, result} for one triple
    function automatic logic [32:0] model_expect(input logic [31:0] a, input logic [31:0] b,
                                                 input logic [31:0] c, input int lat, input int err);
        if ((err == 0 || err == 4) && lat_ok(lat)) begin
            return {1'b0, stub_fn(a, b, c)};
        end
        return {1'b1, 32'hFFFF_FFFF};
    endfunction

    // ---------------- monitor, scoreboard and FMA stub ----------------
    always @(negedge clk) begin
        cyc++;
        bus.fma_ready     <= 1'b0;
        bus.fma_error     <= 1'b0;
        bus.fma_float_out <= 32'h0BAD_F00D;

        // WAIT-phase countdown keeps running across reset (late answers)
        if (ph == 4) begin
            wcnt++;
            if (lat_ok(cur.lat) && wcnt == cur.lat) begin
                if (cur.err == 0 || cur.err == 4) begin
                    bus.fma_ready     <= 1'b1;
                    bus.fma_float_out <= stub_fn(cur.a, cur.b, cur.c);
                end
                if (cur.err == 3 || cur.err == 4) begin
                    bus.fma_error <= 1'b1;
                end
                ph = 0;
            end else if (wcnt >= TIMEOUT) begin
                ph = 0;
            end
        end

        if (rst) begin
            plan_q.delete();
            exp_q.delete();
            ov_pend = 0;
            ov_prev = 0;
            if (ph != 4) ph = 0;
        end else begin
            // result side
            if (bus.out_valid && !ov_prev) begin
                if (ov_pend) check("result_latency", cyc, exp_ov_cyc);
                else         check("spurious_out_valid", bus.out_valid, 1'b0);
                ov_pend = 0;
            end
            ov_prev = bus.out_valid;
            if (bus.out_valid) begin
                if (exp_q.size() == 0) begin
                    check("result_without_triple", bus.out_valid, 1'b0);
                end else begin
                    check("result_word", {bus.out_error, bus.out_result}, exp_q[0]);
                    if (bus.out_ready) begin
                        last_hs = {bus.out_error, bus.out_result};
                        void'(exp_q.pop_front());
                    end
                end
            end

            // input side
            if (bus.in_valid && bus.in_ready) begin
                plan_q.push_back('{bus.in_a, bus.in_b, bus.in_c, drv_lat, drv_err});
                exp_q.push_back(drv_exp);
                push_cyc = cyc;
            end

            // operand bus
            case (ph)
                2: begin
                    check("operand_b", bus.fma_float_in, cur.b);
                    check("start_only_on_a", bus.fma_start, 1'b0);
                    if (cur.err == 1) begin
                        bus.fma_error <= 1'b1;
                        exp_ov_cyc = cyc + 1;
                        ov_pend = 1;
                        ph = 0;
                    end else begin
                        ph = 3;
                    end
                end
                3: begin
                    check("operand_c", bus.fma_float_in, cur.c);
                    check("start_only_on_a", bus.fma_start, 1'b0);
                    if (cur.err == 2) begin
                        bus.fma_error <= 1'b1;
                        exp_ov_cyc = cyc + 1;
                        ov_pend = 1;
                        ph = 0;
                    end else begin
                        wcnt = 0;
                        exp_ov_cyc = cyc + (lat_ok(cur.lat) ? cur.lat : TIMEOUT) + 1;
                        ov_pend = 1;
                        ph = 4;
                    end
                end
                default: begin
                    if (bus.fma_start) begin
                        if (ph == 4 || plan_q.size() == 0) begin
                            check("unexpected_start", bus.fma_start, 1'b0);
                        end else begin
                            cur = plan_q.pop_front();
                            start_cyc = cyc;
                            check("operand_a", bus.fma_float_in, cur.a);
                            ph = 2;
                        end
                    end else begin
                        check("bus_idle_zero", bus.fma_float_in, 32'h0);
                        if (ph == 0 && spur_req) begin
                            bus.fma_ready     <= 1'b1;
                            bus.fma_error     <= 1'b1;
                            bus.fma_float_out <= 32'hDEAD_BEEF;
                            spur_req = 0;
                        end
                    end
                end
            endcase
        end
    end

    // ---------------- driver tasks ----------------
    task automatic push(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                        input int lat, input int err, input logic [32:0] exp);
        int g;
        bit ok;
        g  = 0;
        ok = 0;
        @(posedge clk);
        #1;
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_c     = c;
        drv_lat      = lat;
        drv_err      = err;
        drv_exp      = exp;
        bus.in_valid = 1'b1;
        while (!ok && g < 2000) begin
            @(negedge clk);
            ok = bus.in_ready;
            g++;
        end
        if (!ok) check("push_accept_timeout", ok, 1'b1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int g;
        g = 0;
        while ((exp_q.size() != 0 || ov_pend || ph != 0) && g < 3000) begin
            @(negedge clk);
            g++;
        end
        if (g >= 3000) check("drain_timeout", exp_q.size(), 0);
        @(negedge clk);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #500000;
        $display("FAIL watchdog: got no completion expected finish within time limit");
        $fatal(1, "watchdog expired");
    end

    // ---------------- test sequence ----------------
    initial begin
        vec_t vecs[9];
        bit   ov_seen;
        int   g;

        vecs[0] = '{32'h3FE0_0000, 32'h3FC0_0000, 32'h3F80_0000,  5, 0, 32'h4068_0000, 1'b0};
        vecs[1] = '{32'h0000_0001, 32'h0000_0002, 32'h0000_0003,  1, 0, 32'h0000_0006, 1'b0};
        vecs[2] = '{32'h0000_0010, 32'h0000_0020, 32'h0000_0030, 16, 0, 32'h0000_0060, 1'b0};
        vecs[3] = '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333,  0, 0, 32'hFFFF_FFFF, 1'b1};
        vecs[4] = '{32'h0000_0005, 32'h0000_0006, 32'h0000_0007,  3, 1, 32'hFFFF_FFFF, 1'b1};
        vecs[5] = '{32'h0000_0008, 32'h0000_0009, 32'h0000_000A,  3, 2, 32'hFFFF_FFFF, 1'b1};
        vecs[6] = '{32'h0000_0100, 32'h0000_0200, 32'h0000_0300,  4, 3, 32'hFFFF_FFFF, 1'b1};
        vecs[7] = '{32'h7F00_0000, 32'h0100_0000, 32'h0000_0001,  2, 4, 32'h8000_0001, 1'b0};
        vecs[8] = '{32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000,  7, 0, 32'h0000_0000, 1'b0};

        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.in_c      = '0;
        bus.out_ready = 1'b1;

        // reset state
        #12;
        check("rst_in_ready", bus.in_ready, 1'b0);
        check("rst_out_valid", bus.out_valid, 1'b0);
        check("rst_fma_start", bus.fma_start, 1'b0);
        check("rst_fma_float_in", bus.fma_float_in, 32'h0);
        check("rst_out_result", bus.out_result, 32'h0);
        check("rst_out_error", bus.out_error, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("in_ready_after_release", bus.in_ready, 1'b1);

        // table vectors, one at a time from idle
        for (int i = 0; i < 9; i++) begin
            push(vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].lat, vecs[i].err,
                 {vecs[i].exp_err, vecs[i].exp_res});
            wait_drain();
            check("vec_result", last_hs, {vecs[i].exp_err, vecs[i].exp_res});
            check("vec_start_latency", start_cyc - push_cyc, 2);
        end

        // back-pressure: four stored plus one in flight fills the sequencer
        bus.out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            push(32'h100 * (i + 1), 32'h10 + i, 32'h1 + i, 2, 0,
                 model_expect(32'h100 * (i + 1), 32'h10 + i, 32'h1 + i, 2, 0));
        end
        @(negedge clk);
        check("full_in_ready_low", bus.in_ready, 1'b0);
        repeat (8) @(negedge clk);
        check("full_in_ready_held", bus.in_ready, 1'b0);
        check("full_out_valid_held", bus.out_valid, 1'b1);
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        wait_drain();
        check("drain_order_last", last_hs, {1'b0, 32'h500 + 32'h14 + 32'h5});

        // asynchronous reset in WAIT, then a late FMA answer
        push(32'hABCD_0000, 32'h0000_1234, 32'h0000_0001, 12, 0,
             model_expect(32'hABCD_0000, 32'h0000_1234, 32'h0000_0001, 12, 0));
        g = 0;
        while (ph != 4 && g < 100) begin
            @(negedge clk);
            g++;
        end
        if (g >= 100) check("reach_wait_timeout", ph, 4);
        repeat (3) @(negedge clk);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("midrst_out_valid", bus.out_valid, 1'b0);
        check("midrst_in_ready", bus.in_ready, 1'b0);
        check("midrst_fma_start", bus.fma_start, 1'b0);
        check("midrst_fma_float_in", bus.fma_float_in, 32'h0);
        check("midrst_out_result", bus.out_result, 32'h0);
        check("midrst_out_error", bus.out_error, 1'b0);
        @(negedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("midrst_in_ready_release", bus.in_ready, 1'b1);
        ov_seen = 0;
        repeat (25) begin
            @(negedge clk);
            ov_seen = ov_seen | bus.out_valid;
        end
        check("late_ready_ignored", ov_seen, 1'b0);

        // FMA pulses while idle
        spur_req = 1;
        ov_seen = 0;
        repeat (6) begin
            @(negedge clk);
            ov_seen = ov_seen | bus.out_valid;
        end
        check("idle_ready_ignored", ov_seen, 1'b0);

        // random traffic with random consumer stalls
        rnd_done = 0;
        fork
            begin
                for (int i = 0; i < 40; i++) begin
                    logic [31:0] ra, rb, rc;
                    int r, rl, re;
                    ra = $urandom;
                    rb = $urandom;
                    rc = $urandom;
                    r  = $urandom_range(0, 9);
                    re = (r < 4) ? r + 1 : 0;
                    rl = $urandom_range(0, TIMEOUT);
                    repeat ($urandom_range(0, 3)) begin
                        @(posedge clk);
                        #1;
                    end
                    push(ra, rb, rc, rl, re, model_expect(ra, rb, rc, rl, re));
                end
                rnd_done = 1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge clk);
                    #1;
                    bus.out_ready = ($urandom_range(0, 3) != 0);
                end
                bus.out_ready = 1'b1;
            end
        join
        wait_drain();
        check("random_all_drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fma_operand_sequencer.md
FMA_OPERAND_SEQUENCER -- requirements
Module: fma_operand_sequencer

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, meaning triple-FIFO entries (power of 2, >=2).
REQ-002 SHALL have parameter TIMEOUT, default 16, meaning max WAIT cycles before abort.
REQ-003 SHALL have port clk  in  1  sole clock, rising edge.
REQ-004 SHALL have port rst  in  1  reset, asynchronous and active-high.
REQ-005 SHALL have port in_valid  in  1  operand triple offered.
REQ-006 SHALL have port in_ready  out  1  sequencer can accept a triple.
REQ-007 SHALL have ports in_a, in_b, in_c  in  32 each  IEEE-754 single operands, y = a*b + c.
REQ-008 SHALL have port fma_start  out  1  start pulse to FMA.
REQ-009 SHALL have port fma_float_in  out  32  serial operand bus to FMA.
REQ-010 SHALL have port fma_float_out  in  32  FMA result.
REQ-011 SHALL have port fma_ready  in  1  FMA result-valid pulse.
REQ-012 SHALL have port fma_error  in  1  FMA error flag.
REQ-013 SHALL have port out_valid  out  1  result held.
REQ-014 SHALL have port out_ready  in  1  consumer accepts result.
REQ-015 SHALL have ports out_result  out  32, and out_error  out  1, the result word and its error flag.

Function
REQ-016 SHALL buffer triples in a FIFO of FIFO_DEPTH; push when in_valid && in_ready; in_ready = !full (no bypass, no push when full even if popping).
REQ-017 SHALL implement states IDLE, SEND_A, SEND_B, SEND_C, WAIT, RESULT.
REQ-018 IDLE -> SEND_A when FIFO non-empty and out_valid==0, popping the head into an operand register on that edge; else stay IDLE.
REQ-019 SEND_A: fma_start=1, fma_float_in=a; SEND_B: fma_float_in=b; SEND_C: fma_float_in=c; each exactly one cycle, in that order.
REQ-020 fma_start SHALL be 1 only in SEND_A; fma_float_in SHALL be 0 outside SEND_A/B/C.
REQ-021 SEND_C -> WAIT; WAIT counts cycles from 0; WAIT -> RESULT when fma_ready, fma_error, or count == TIMEOUT-1.
REQ-022 On fma_ready (priority over error/timeout): capture fma_float_out, out_error=0.
REQ-023 On fma_error or timeout: out_result=32'hFFFF_FFFF, out_error=1.
REQ-024 fma_error high in SEND_B or SEND_C SHALL abort directly to RESULT with error as REQ-023.
REQ-025 RESULT: out_valid=1 held with stable out_result/out_error until out_ready; on out_valid && out_ready -> IDLE and out_valid=0 next cycle.
REQ-026 fma_ready/fma_error in IDLE or RESULT SHALL be ignored.
REQ-027 Results SHALL emerge in FIFO order, one triple in flight at a time.
REQ-028 FIFO pointers SHALL wrap modulo FIFO_DEPTH; full/empty from a count of width clog2(FIFO_DEPTH)+1.
REQ-029 Minimum latency: triple accepted at edge E -> fma_start high in cycle after edge E+1.

Reset
REQ-030 rst SHALL immediately (no clock) force state IDLE, FIFO empty, counters 0, fma_start=0, fma_float_in=0, out_valid=0, out_result=0, out_error=0.
REQ-031 in_ready SHALL be 0 while rst high, 1 in the first cycle after release.
REQ-032 rst asserted mid-operation SHALL discard the in-flight triple and all FIFO contents; later fma_ready SHALL be ignored.

Verification
REQ-033 Push a=0x3FE00000, b=0x3FC00000, c=0x3F800000; stub returns 0x40680000 with fma_ready 5 cycles after SEND_C -> fma_float_in sequence a,b,c with fma_start on a only; out_result=0x40680000, out_error=0.
REQ-034 Push 5 triples with out_ready=0, FIFO_DEPTH=4 -> in_ready low after 4 stored plus 1 in flight; results drain in push order when out_ready=1.
REQ-035 Stub never asserts fma_ready -> RESULT after exactly TIMEOUT WAIT cycles; out_result=0xFFFFFFFF, out_error=1.
REQ-036 Stub asserts fma_error during SEND_B -> no SEND_C cycle; out_error=1, out_result=0xFFFFFFFF.
REQ-037 Assert rst between clock edges during WAIT -> all outputs reset values same cycle; late fma_ready produces no out_valid.
REQ-038 Stub pulses fma_ready while in IDLE -> out_valid stays 0.
